// File: rtl/panel_loader.sv
// rtl/panel_loader.sv - front-panel image loader
// Streams (addr,data) words into PDP8 memory via timed load/deposit pulses, then loads PC and runs.
module panel_loader #(
   parameter int SETUP_CYCLES = 10,
   parameter int PULSE_CYCLES = 10,
   parameter int GAP_CYCLES   = 30
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] start_pc,
   input  logic        word_valid,
   output logic        word_ready,
   input  logic [11:0] word_addr,
   input  logic [11:0] word_data,
   input  logic        word_last,
   output logic [12:0] sw,
   output logic        load_pc_btn,
   output logic        deposit_btn,
   output logic        busy,
   output logic        done,
   output logic [12:0] words_loaded
);

   typedef enum logic [2:0] {IDLE, WAIT_WORD, ADDR_PH, DATA_PH, PC_PH, RUN} state_t;
   typedef enum logic [1:0] {SUB_SETUP, SUB_PULSE, SUB_GAP} sub_t;

   localparam logic [7:0] LP_S = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] LP_P = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] LP_G = 8'(GAP_CYCLES - 1);

   state_t      r_state;
   sub_t        r_sub;
   logic [7:0]  r_cnt;
   logic [11:0] r_pc;
   logic [11:0] r_data;
   logic        r_last;
   logic [12:0] r_sw;
   logic        r_load_pc;
   logic        r_deposit;
   logic        r_ready;
   logic        r_busy;
   logic        r_done;
   logic [12:0] r_words;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_sub     <= SUB_SETUP;
         r_cnt     <= '0;
         r_pc      <= '0;
         r_data    <= '0;
         r_last    <= 1'b0;
         r_sw      <= '0;
         r_load_pc <= 1'b0;
         r_deposit <= 1'b0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_words   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_pc    <= start_pc;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b1;
                  r_words <= '0;
                  r_state <= WAIT_WORD;
               end
            end
            WAIT_WORD: begin
               if (word_valid && r_ready) begin
                  r_ready     <= 1'b0;
                  r_sw[11:0]  <= word_addr;
                  r_data      <= word_data;
                  r_last      <= word_last;
                  r_sub       <= SUB_SETUP;
                  r_cnt       <= LP_S;
                  r_state     <= ADDR_PH;
               end
            end
            ADDR_PH, DATA_PH, PC_PH: begin
               // Each phase: setup (button low), pulse (button high), gap (button low).
               if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else begin
                  case (r_sub)
                     SUB_SETUP: begin
                        r_sub <= SUB_PULSE;
                        r_cnt <= LP_P;
                        if (r_state == DATA_PH) r_deposit <= 1'b1;
                        else                    r_load_pc <= 1'b1;
                     end
                     SUB_PULSE: begin
                        r_sub     <= SUB_GAP;
                        r_cnt     <= LP_G;
                        r_load_pc <= 1'b0;
                        r_deposit <= 1'b0;
                     end
                     default: begin
                        r_sub <= SUB_SETUP;
                        r_cnt <= LP_S;
                        case (r_state)
                           ADDR_PH: begin
                              r_sw[11:0] <= r_data;
                              r_state    <= DATA_PH;
                           end
                           DATA_PH: begin
                              if (r_words != 13'd4096) r_words <= r_words + 13'd1;
                              if (r_last) begin
                                 r_sw[11:0] <= r_pc;
                                 r_state    <= PC_PH;
                              end else begin
                                 r_ready <= 1'b1;
                                 r_state <= WAIT_WORD;
                              end
                           end
                           default: begin
                              r_sw[12] <= 1'b1;
                              r_done   <= 1'b1;
                              r_busy   <= 1'b0;
                              r_state  <= RUN;
                           end
                        endcase
                     end
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign word_ready   = r_ready;
   assign sw           = r_sw;
   assign load_pc_btn  = r_load_pc;
   assign deposit_btn  = r_deposit;
   assign busy         = r_busy;
   assign done         = r_done;
   assign words_loaded = r_words;

endmodule
